// File: rtl/led_sched_pkg.sv
// Shared types and default timing for the LED status scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    GAP   = 2'd2,
    PAUSE = 2'd3
  } led_state_e;

  localparam int DEF_TICK_DIV = 12288;
  localparam int DEF_ON_MS    = 100;
  localparam int DEF_OFF_MS   = 150;
  localparam int DEF_PAUSE_MS = 500;

  localparam int FC_W = 4;
  localparam int MS_W = 16;

  // A programmed flash count of zero still shows one flash.
  function automatic logic [FC_W-1:0] fc_clamp(input logic [FC_W-1:0] n);
    return (n == '0) ? FC_W'(1) : n;
  endfunction

endpackage

// File: rtl/led_ms_timer.sv
// Prescaler plus millisecond down-counter; expired pulses in the last cycle
// of a load_ms*TICK_DIV cycle interval that starts the cycle after load.
module led_ms_timer
  import led_sched_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [MS_W-1:0] load_ms,
  output logic            expired
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]   pre_q, pre_d;
  logic [MS_W-1:0] ms_q, ms_d;

  assign expired = (ms_q == MS_W'(1)) && (pre_q == PRE_MAX);

  always_comb begin
    pre_d = pre_q;
    ms_d  = ms_q;
    if (load) begin
      pre_d = '0;
      ms_d  = load_ms;
    end else if (pre_q == PRE_MAX) begin
      pre_d = '0;
      // Parks at zero so an unattended timer never pulses again.
      if (ms_q != '0) ms_d = ms_q - MS_W'(1);
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else begin
      pre_q <= pre_d;
      ms_q  <= ms_d;
    end
  end

endmodule

// File: rtl/led_status_scheduler.sv
// Multiplexes NUM_REQ status requesters onto one LED as N-flash bursts.
// Define LED_SCHED_PREEMPT_EN to let lower-index requests abort a burst.
module led_status_scheduler
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int ON_MS    = DEF_ON_MS,
  parameter int OFF_MS   = DEF_OFF_MS,
  parameter int PAUSE_MS = DEF_PAUSE_MS
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_en,
  input  logic [FC_W*NUM_REQ-1:0] flash_count,
  output logic                    led,
  output logic [2:0]              active_id,
  output logic                    busy
);

  led_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  pending_q, pending_d;
  logic [NUM_REQ-1:0]  clr;
  logic [2:0]          active_q, active_d;
  logic [FC_W-1:0]     cnt_q, cnt_d, cnt_dec;
  logic                led_q, led_d;
  logic                abort_q, abort_d;
  logic                load;
  logic [MS_W-1:0]     load_ms;
  logic                expired;
  logic                pause_done;
  logic                preempt;
  logic [2:0]          grant;
  logic [FC_W-1:0]     fc_field [8];

  led_ms_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk     (clock),
    .reset_n (reset_n),
    .load    (load),
    .load_ms (load_ms),
    .expired (expired)
  );

  assign pause_done = (state_q == PAUSE) && expired;

  // Padded to 8 entries so a 3-bit grant indexes it directly.
  for (genvar gi = 0; gi < 8; gi++) begin : g_fc
    if (gi < NUM_REQ) begin : g_used
      assign fc_field[gi] = flash_count[FC_W*gi +: FC_W];
    end else begin : g_pad
      assign fc_field[gi] = '0;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pend
    assign clr[gi]       = pause_done && !abort_q && (active_q == 3'(gi));
    assign pending_d[gi] = (req[gi] & req_en[gi]) |
                           (pending_q[gi] & req_en[gi] & ~clr[gi]);
  end

  always_comb begin
    grant = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) grant = 3'(i);
    end
  end

`ifdef LED_SCHED_PREEMPT_EN
  logic lower_pending;
  always_comb begin
    lower_pending = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pending_q[i] && (3'(i) < active_q)) lower_pending = 1'b1;
    end
  end
  assign preempt = lower_pending;
`else
  assign preempt = 1'b0;
`endif

  assign cnt_dec = cnt_q - FC_W'(1);

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    abort_d  = abort_q;
    load     = 1'b0;
    load_ms  = '0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d  = SHOW;
          active_d = grant;
          cnt_d    = fc_clamp(fc_field[grant]);
          led_d    = 1'b1;
          abort_d  = 1'b0;
          load     = 1'b1;
          load_ms  = MS_W'(ON_MS);
        end
      end
      SHOW: begin
        if (expired) begin
          cnt_d = cnt_dec;
          led_d = 1'b0;
          load  = 1'b1;
          if (cnt_dec != '0 && !preempt) begin
            state_d = GAP;
            load_ms = MS_W'(OFF_MS);
          end else begin
            // An aborted burst keeps its pending bit so it replays in full.
            state_d = PAUSE;
            load_ms = MS_W'(PAUSE_MS);
            abort_d = (cnt_dec != '0);
          end
        end
      end
      GAP: begin
        if (expired) begin
          state_d = SHOW;
          led_d   = 1'b1;
          load    = 1'b1;
          load_ms = MS_W'(ON_MS);
        end
      end
      PAUSE: begin
        if (expired) begin
          state_d = IDLE;
          load    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      active_q  <= 3'd0;
      cnt_q     <= '0;
      led_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      abort_q   <= abort_d;
    end
  end

  assign led       = led_q;
  assign active_id = active_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_led_status_scheduler.sv
// Bench for led_status_scheduler: burst-timeline model checked every cycle,
// plus literal burst patterns per directed scenario.
module tb_led_status_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int TICK_DIV = 4;
  localparam int ON_MS    = 2;
  localparam int OFF_MS   = 3;
  localparam int PAUSE_MS = 5;
  localparam int ON_C     = ON_MS * TICK_DIV;
  localparam int OFF_C    = OFF_MS * TICK_DIV;
  localparam int PAUSE_C  = PAUSE_MS * TICK_DIV;

  logic                 clk;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_en;
  logic [4*NUM_REQ-1:0] fc;
  logic                 led;
  logic [2:0]           active_id;
  logic                 busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  led_status_scheduler #(
    .NUM_REQ(NUM_REQ), .TICK_DIV(TICK_DIV), .ON_MS(ON_MS),
    .OFF_MS(OFF_MS), .PAUSE_MS(PAUSE_MS)
  ) dut (
    .clock(clk), .reset_n(reset_n), .req(req), .req_en(req_en),
    .flash_count(fc), .led(led), .active_id(active_id), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: a burst is a queue of (level, length) segments consumed per cycle.
  bit [7:0] m_pend;
  bit       m_busy, m_led, m_abort;
  int       m_id, m_left;
  int       seg_len[$];
  bit       seg_led[$];

  task automatic model_step();
    bit [7:0] set_v, en_v, pend_old, clr_v;
    int g, n;
    if (!reset_n) begin
      m_pend = '0; m_busy = 0; m_led = 0; m_id = 0; m_abort = 0; m_left = 0;
      seg_len.delete(); seg_led.delete();
      return;
    end
    set_v = 8'(req & req_en);
    en_v = 8'(req_en);
    pend_old = m_pend;
    clr_v = '0;
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
`ifdef LED_SCHED_PREEMPT_EN
        if (seg_led[0] && seg_len.size() > 2 && (pend_old & ((8'd1 << m_id) - 8'd1)) != 0) begin
          while (seg_len.size() > 1) begin
            void'(seg_len.pop_back()); void'(seg_led.pop_back());
          end
          seg_len.push_back(PAUSE_C); seg_led.push_back(1'b0);
          m_abort = 1;
        end
`endif
        void'(seg_len.pop_front()); void'(seg_led.pop_front());
        if (seg_len.size() == 0) begin
          m_busy = 0; m_led = 0;
          if (!m_abort) clr_v[m_id] = 1'b1;
        end else begin
          m_left = seg_len[0]; m_led = seg_led[0];
        end
      end
    end else if (pend_old != 0) begin
      g = 0;
      while (!pend_old[g]) g++;
      n = int'(fc[4*g +: 4]);
      if (n == 0) n = 1;
      for (int k = 0; k < n; k++) begin
        seg_len.push_back(ON_C); seg_led.push_back(1'b1);
        if (k < n - 1) begin seg_len.push_back(OFF_C); seg_led.push_back(1'b0); end
      end
      seg_len.push_back(PAUSE_C); seg_led.push_back(1'b0);
      m_busy = 1; m_led = 1; m_id = g; m_left = ON_C; m_abort = 0;
    end
    m_pend = set_v | (pend_old & en_v & ~clr_v);
  endtask

  // Burst monitor: records "<id>:<run>/<run>/..." for each busy interval.
  string log_q[$];
  int    burst_start[$];
  bit    in_burst = 0;
  string cur_runs;
  int    cur_id, run_len;
  logic  run_lvl;

  task automatic monitor();
    if (!in_burst && busy === 1'b1) begin
      in_burst = 1; cur_id = int'(active_id); cur_runs = "";
      run_lvl = led; run_len = 1; burst_start.push_back(cyc);
    end else if (in_burst && busy === 1'b1) begin
      if (led === run_lvl) run_len++;
      else begin
        cur_runs = {cur_runs, $sformatf("%0d/", run_len)};
        run_lvl = led; run_len = 1;
      end
    end else if (in_burst) begin
      log_q.push_back($sformatf("%0d:%s%0d", cur_id, cur_runs, run_len));
      in_burst = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      check("led", 32'(led), 32'(m_led));
      check("busy", 32'(busy), 32'(m_busy));
      check("active_id", 32'(active_id), 32'(m_id));
      monitor();
    end
  end

  task automatic expect_burst(input string exp);
    string got;
    checks++;
    if (log_q.size() == 0) begin
      errors++;
      $display("FAIL burst: got none expected %s", exp);
    end else begin
      got = log_q.pop_front();
      if (got != exp) begin
        errors++;
        $display("FAIL burst: got %s expected %s", got, exp);
      end
    end
  endtask

  task automatic check_spacing(input string name, input int exp);
    if (burst_start.size() < 2) check(name, 32'(burst_start.size()), 32'd2);
    else check(name, 32'(burst_start[1] - burst_start[0]), 32'(exp));
  endtask

  task automatic clear_log();
    log_q.delete();
    burst_start.delete();
  endtask

  task automatic pulse(input int idx);
    @(negedge clk); req[idx] = 1'b1;
    @(negedge clk); req[idx] = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req = '0; req_en = '1; fc = '0;
    repeat (3) @(negedge clk);
    check("rst_led", 32'(led), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_id", 32'(active_id), 32'd0);
    reset_n = 1'b1;

    // 1: three flashes for requester 2
    fc[11:8] = 4'd3; clear_log();
    pulse(2);
    repeat (80) @(negedge clk);
    expect_burst("2:8/12/8/12/8/20");
    check("t1_log_empty", 32'(log_q.size()), 32'd0);

    // 2: simultaneous 0 and 3, priority to 0, one IDLE cycle between
    fc[3:0] = 4'd1; fc[15:12] = 4'd1; clear_log();
    @(negedge clk); req = 4'b1001;
    @(negedge clk); req = 4'b0000;
    repeat (70) @(negedge clk);
    check_spacing("t2_spacing", 29);
    expect_burst("0:8/20");
    expect_burst("3:8/20");
    check("t2_log_empty", 32'(log_q.size()), 32'd0);

    // 3: flash count 0 acts as 1
    fc[7:4] = 4'd0; clear_log();
    pulse(1);
    repeat (40) @(negedge clk);
    expect_burst("1:8/20");
    check("t3_log_empty", 32'(log_q.size()), 32'd0);

    // 4: held request repeats; dropping enable mid-burst lets it finish
    fc[7:4] = 4'd2; clear_log();
    @(negedge clk); req[1] = 1'b1;
    repeat (60) @(negedge clk);
    req_en[1] = 1'b0;
    repeat (70) @(negedge clk);
    req[1] = 1'b0; req_en[1] = 1'b1;
    check_spacing("t4_spacing", 49);
    expect_burst("1:8/12/8/20");
    expect_burst("1:8/12/8/20");
    check("t4_log_empty", 32'(log_q.size()), 32'd0);

    // 5: reset three cycles into SHOW
    clear_log();
    pulse(2);
    repeat (3) @(negedge clk);
    check("t5_busy_before", 32'(busy), 32'd1);
    check("t5_id_before", 32'(active_id), 32'd2);
    reset_n = 1'b0;
    @(posedge clk); #2;
    check("t5_led", 32'(led), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_id", 32'(active_id), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (30) @(negedge clk);
    expect_burst("2:3");
    check("t5_no_resume", 32'(log_q.size()), 32'd0);
    check("t5_led_low", 32'(led), 32'd0);

    // 6: lower-index request arrives during a 4-flash burst
    fc[15:12] = 4'd4; fc[3:0] = 4'd1; clear_log();
    pulse(3);
    repeat (4) @(negedge clk);
    pulse(0);
    repeat (170) @(negedge clk);
`ifdef LED_SCHED_PREEMPT_EN
    expect_burst("3:8/20");
    expect_burst("0:8/20");
    expect_burst("3:8/12/8/12/8/12/8/20");
`else
    expect_burst("3:8/12/8/12/8/12/8/20");
    expect_burst("0:8/20");
`endif
    check("t6_log_empty", 32'(log_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
